a2d_resp: RTL and testbench

SPI responder for the slide-pot A2D path: the slave end of the ADC link that the equalizer's A2D master drives over A2D_SS_n/A2D_SCLK/A2D_MOSI/A2D_MISO. It holds eight 12-bit channel values and decodes the channel field of each 16-bit frame. It returns the addressed value one frame later, giving the same one-frame pipeline as the physical ADC. The equalizer uses it as a synthesizable stand-in for the ADC during bring-up and full-chip simulation.

---
 rtl/a2d_resp_pkg.sv | 26 ++
 rtl/a2d_resp_if.sv | 30 +++
 rtl/a2d_resp_spi_edge_sync.sv | 29 ++
 rtl/a2d_resp.sv | 121 ++++++++++++
 tb/tb_a2d_resp.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/a2d_resp_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : a2d_pkg
//  Brief   : Shared constants and state encoding for the A2D SPI responder.
//  Rev     : 1.0  initial release
// ============================================================================
package a2d_pkg;

  localparam int FRAME_BITS = 16;
  localparam int CH_MSB     = 13;
  localparam int CH_LSB     = 11;
  localparam int RES_W      = 12;
  localparam int NUM_CH     = 8;
  localparam int CH_W       = $clog2(NUM_CH);
  localparam int CNT_W      = $clog2(FRAME_BITS) + 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/a2d_resp_if.sv
`default_nettype none
// ============================================================================
//  Module  : a2d_resp_if
//  Brief   : SPI link plus channel-register write port of the A2D responder.
//  Rev     : 1.0  initial release
// ============================================================================
interface a2d_resp_if;

  logic                       SS_n;
  logic                       SCLK;
  logic                       MOSI;
  logic                       MISO;
  logic                       wr_en;
  logic [a2d_pkg::CH_W-1:0]   wr_chnnl;
  logic [a2d_pkg::RES_W-1:0]  wr_data;
  logic                       frame_done;
  logic [a2d_pkg::CH_W-1:0]   last_chnnl;

  modport master (
    output SS_n, SCLK, MOSI, wr_en, wr_chnnl, wr_data,
    input  MISO, frame_done, last_chnnl
  );

  modport slave (
    input  SS_n, SCLK, MOSI, wr_en, wr_chnnl, wr_data,
    output MISO, frame_done, last_chnnl
  );

endinterface
`default_nettype wire

// File: rtl/a2d_resp_spi_edge_sync.sv
`default_nettype none
// ============================================================================
//  Module  : spi_edge_sync
//  Brief   : 2-flop synchronizer with one-clk rise/fall pulses on its output.
//  Rev     : 1.0  initial release
// ============================================================================
module spi_edge_sync #(
  parameter logic RST_LVL = 1'b0
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic din,
  output logic      rise,
  output logic      fall
);

  // [1:0] is the synchronizer, [2] holds the previous synchronized level
  logic [2:0] r_sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sh <= {3{RST_LVL}};
    else        r_sh <= {r_sh[1:0], din};
  end

  assign rise =  r_sh[1] & ~r_sh[2];
  assign fall = ~r_sh[1] &  r_sh[2];

endmodule
`default_nettype wire

// File: rtl/a2d_resp.sv
`default_nettype none
// ============================================================================
//  Module  : a2d_resp
//  Brief   : SPI-mode-0 ADC stand-in; returns the channel addressed last frame.
//  Rev     : 1.0  initial release
// ============================================================================
module a2d_resp
  import a2d_pkg::*;
#(
  parameter logic [RES_W-1:0] RST_VAL = 12'h800
) (
  input  wire logic clk,
  input  wire logic rst_n,
  a2d_resp_if.slave bus
);

  logic ss_rise, ss_fall, sclk_rise, sclk_fall;
  logic [1:0] mosi_ff;
  logic mosi_s;

  state_t state, state_nxt;

  logic [CNT_W-1:0]      bit_cnt;
  logic [FRAME_BITS-2:0] tx_sr;      // bits still to send; MSB lives in miso
  logic [CH_MSB:0]       rx_sr;      // only the channel field and below matter
  logic [CH_W-1:0]       pend_ch;
  logic                  miso;
  logic                  frame_done;
  logic [RES_W-1:0]      ch_reg [NUM_CH];
  logic [FRAME_BITS-1:0] tx_load;

  // SS_n sync resets low so a select already asserted at reset release
  // produces no fall; the next frame waits for a genuine SS_n fall.
  spi_edge_sync #(.RST_LVL(1'b0)) u_ss_sync (
    .clk(clk), .rst_n(rst_n), .din(bus.SS_n), .rise(ss_rise), .fall(ss_fall)
  );

  spi_edge_sync #(.RST_LVL(1'b0)) u_sclk_sync (
    .clk(clk), .rst_n(rst_n), .din(bus.SCLK), .rise(sclk_rise), .fall(sclk_fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mosi_ff <= 2'b00;
    else        mosi_ff <= {mosi_ff[0], bus.MOSI};
  end
  assign mosi_s = mosi_ff[1];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                   ch_reg[g] <= RST_VAL;
      else if (bus.wr_en && bus.wr_chnnl == CH_W'(g)) ch_reg[g] <= bus.wr_data;
    end
  end

  assign tx_load = {{(FRAME_BITS-RES_W){1'b0}}, ch_reg[pend_ch]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ss_fall) state_nxt = SHIFT;
      SHIFT:   if (ss_rise) state_nxt = IDLE;
               else if (sclk_rise && bit_cnt == CNT_LAST) state_nxt = DONE;
      DONE:    if (ss_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt    <= '0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      pend_ch    <= '0;
      miso       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: if (ss_fall) begin
          tx_sr   <= tx_load[FRAME_BITS-2:0];
          miso    <= tx_load[FRAME_BITS-1];
          bit_cnt <= '0;
        end
        SHIFT: if (ss_rise) begin
          bit_cnt <= '0;
          miso    <= 1'b0;
        end else begin
          if (sclk_rise) begin
            rx_sr   <= {rx_sr[CH_MSB-1:0], mosi_s};
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
          if (sclk_fall) begin
            tx_sr <= {tx_sr[FRAME_BITS-3:0], 1'b0};
            miso  <= tx_sr[FRAME_BITS-2];
          end
        end
        DONE: if (ss_rise) begin
          pend_ch    <= rx_sr[CH_MSB:CH_LSB];
          frame_done <= 1'b1;
          bit_cnt    <= '0;
          miso       <= 1'b0;
        end else if (sclk_fall) begin
          miso <= 1'b0;
        end
        default: miso <= 1'b0;
      endcase
    end
  end

  // last_chnnl always equals the pending channel, so one register serves both
  assign bus.MISO       = miso;
  assign bus.frame_done = frame_done;
  assign bus.last_chnnl = pend_ch;

endmodule
`default_nettype wire

// File: tb/tb_a2d_resp.sv
`default_nettype none
// ============================================================================
//  Module  : tb_a2d_resp
//  Brief   : Directed self-checking bench for the A2D SPI responder.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_a2d_resp;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  a2d_resp_if bus();

  a2d_resp #(.RST_VAL(12'h800)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int fd_cnt = 0;

  always @(negedge clk) if (bus.frame_done === 1'b1) fd_cnt++;

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_write(input logic [2:0] ch, input logic [11:0] val);
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_chnnl = ch; bus.wr_data = val;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  // SCLK half period is 16 clk; MISO sampled just before each rise.
  task automatic spi_frame(input logic [15:0] mosi, input int nbits,
                           input int wr_at, input logic [2:0] wr_ch,
                           input logic [11:0] wr_val, input int rst_at,
                           output logic [31:0] rd);
    logic [15:0] m;
    m  = mosi;
    rd = '0;
    bus.SS_n = 1'b0;
    wait_clk(16);
    for (int i = 0; i < nbits; i++) begin
      if (i == wr_at) do_write(wr_ch, wr_val);
      if (i == rst_at) begin
        rst_n = 1'b0;
        wait_clk(2);
        n_chk++;
        if (bus.MISO !== 1'b0) begin
          n_fail++; $display("FAIL rst_mid_miso: got %b want 0", bus.MISO);
        end
        n_chk++;
        if (bus.last_chnnl !== 3'd0) begin
          n_fail++; $display("FAIL rst_mid_last: got %0d want 0", bus.last_chnnl);
        end
        rst_n = 1'b1;
        wait_clk(1);
      end
      bus.MOSI = m[15];
      m = m << 1;
      wait_clk(16);
      rd = {rd[30:0], bus.MISO};
      bus.SCLK = 1'b1;
      wait_clk(16);
      bus.SCLK = 1'b0;
    end
    wait_clk(16);
    bus.SS_n = 1'b1;
    bus.MOSI = 1'b0;
    wait_clk(8);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    wait_clk(4);
    n_chk++;
    if (bus.MISO !== 1'b0) begin
      n_fail++; $display("FAIL reset_miso: got %b want 0", bus.MISO);
    end
    n_chk++;
    if (bus.frame_done !== 1'b0) begin
      n_fail++; $display("FAIL reset_frame_done: got %b want 0", bus.frame_done);
    end
    n_chk++;
    if (bus.last_chnnl !== 3'd0) begin
      n_fail++; $display("FAIL reset_last: got %0d want 0", bus.last_chnnl);
    end
    rst_n = 1'b1;
    wait_clk(8);
    n_chk++;
    if (fd_cnt !== 0) begin
      n_fail++; $display("FAIL reset_no_frame_done: got %0d want 0", fd_cnt);
    end
  endtask

  task automatic test_basic;
    logic [31:0] rd;
    int fd0;
    for (int k = 0; k < 2; k++) begin
      fd0 = fd_cnt;
      spi_frame(16'h1800, 16, -1, 3'd0, 12'h0, -1, rd);
      n_chk++;
      if (rd[15:0] !== 16'h0800) begin
        n_fail++; $display("FAIL basic_miso%0d: got %h want 0800", k, rd[15:0]);
      end
      n_chk++;
      if (fd_cnt - fd0 !== 1) begin
        n_fail++; $display("FAIL basic_fd%0d: got %0d want 1", k, fd_cnt - fd0);
      end
      n_chk++;
      if (bus.last_chnnl !== 3'd3) begin
        n_fail++; $display("FAIL basic_last%0d: got %0d want 3", k, bus.last_chnnl);
      end
    end
  endtask

  task automatic test_write;
    logic [31:0] rd;
    do_write(3'd5, 12'hABC);
    spi_frame(16'h2800, 16, -1, 3'd0, 12'h0, -1, rd);
    n_chk++;
    if (rd[15:0] !== 16'h0800) begin
      n_fail++; $display("FAIL write_first: got %h want 0800", rd[15:0]);
    end
    spi_frame(16'h2800, 16, -1, 3'd0, 12'h0, -1, rd);
    n_chk++;
    if (rd[15:0] !== 16'h0ABC) begin
      n_fail++; $display("FAIL write_readback: got %h want 0abc", rd[15:0]);
    end
    n_chk++;
    if (bus.last_chnnl !== 3'd5) begin
      n_fail++; $display("FAIL write_last: got %0d want 5", bus.last_chnnl);
    end
  endtask

  task automatic test_abort;
    logic [31:0] rd;
    int fd0;
    fd0 = fd_cnt;
    spi_frame(16'h3800, 9, -1, 3'd0, 12'h0, -1, rd);
    n_chk++;
    if (rd[8:0] !== 9'h015) begin
      n_fail++; $display("FAIL abort_partial: got %h want 015", rd[8:0]);
    end
    n_chk++;
    if (fd_cnt - fd0 !== 0) begin
      n_fail++; $display("FAIL abort_fd: got %0d want 0", fd_cnt - fd0);
    end
    n_chk++;
    if (bus.last_chnnl !== 3'd5) begin
      n_fail++; $display("FAIL abort_last: got %0d want 5", bus.last_chnnl);
    end
    fd0 = fd_cnt;
    spi_frame(16'h1000, 16, -1, 3'd0, 12'h0, -1, rd);
    n_chk++;
    if (rd[15:0] !== 16'h0ABC) begin
      n_fail++; $display("FAIL abort_next: got %h want 0abc", rd[15:0]);
    end
    n_chk++;
    if (fd_cnt - fd0 !== 1 || bus.last_chnnl !== 3'd2) begin
      n_fail++; $display("FAIL abort_next_fd_last: got fd %0d last %0d want 1 2",
                         fd_cnt - fd0, bus.last_chnnl);
    end
  endtask

  task automatic test_midwrite;
    logic [31:0] rd;
    spi_frame(16'h1000, 16, 5, 3'd2, 12'h123, -1, rd);
    n_chk++;
    if (rd[15:0] !== 16'h0800) begin
      n_fail++; $display("FAIL midwrite_old: got %h want 0800", rd[15:0]);
    end
    spi_frame(16'h0000, 16, -1, 3'd0, 12'h0, -1, rd);
    n_chk++;
    if (rd[15:0] !== 16'h0123) begin
      n_fail++; $display("FAIL midwrite_new: got %h want 0123", rd[15:0]);
    end
  endtask

  task automatic test_overrun;
    logic [31:0] rd;
    int fd0;
    fd0 = fd_cnt;
    spi_frame(16'h3000, 18, -1, 3'd0, 12'h0, -1, rd);
    n_chk++;
    if (rd[17:2] !== 16'h0800) begin
      n_fail++; $display("FAIL overrun_word: got %h want 0800", rd[17:2]);
    end
    n_chk++;
    if (rd[1:0] !== 2'b00) begin
      n_fail++; $display("FAIL overrun_extra: got %b want 00", rd[1:0]);
    end
    n_chk++;
    if (fd_cnt - fd0 !== 1 || bus.last_chnnl !== 3'd6) begin
      n_fail++; $display("FAIL overrun_fd_last: got fd %0d last %0d want 1 6",
                         fd_cnt - fd0, bus.last_chnnl);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd;
    int fd0;
    do_write(3'd6, 12'hFFF);
    do_write(3'd0, 12'h555);
    fd0 = fd_cnt;
    spi_frame(16'h2000, 16, -1, 3'd0, 12'h0, 8, rd);
    n_chk++;
    if (rd[15:0] !== 16'h0F00) begin
      n_fail++; $display("FAIL rst_mid_word: got %h want 0f00", rd[15:0]);
    end
    n_chk++;
    if (fd_cnt - fd0 !== 0 || bus.last_chnnl !== 3'd0) begin
      n_fail++; $display("FAIL rst_mid_fd_last: got fd %0d last %0d want 0 0",
                         fd_cnt - fd0, bus.last_chnnl);
    end
    fd0 = fd_cnt;
    spi_frame(16'h0800, 16, -1, 3'd0, 12'h0, -1, rd);
    n_chk++;
    if (rd[15:0] !== 16'h0800) begin
      n_fail++; $display("FAIL rst_mid_next: got %h want 0800", rd[15:0]);
    end
    n_chk++;
    if (fd_cnt - fd0 !== 1 || bus.last_chnnl !== 3'd1) begin
      n_fail++; $display("FAIL rst_mid_next_fd_last: got fd %0d last %0d want 1 1",
                         fd_cnt - fd0, bus.last_chnnl);
    end
  endtask

  initial begin
    bus.SS_n     = 1'b1;
    bus.SCLK     = 1'b0;
    bus.MOSI     = 1'b0;
    bus.wr_en    = 1'b0;
    bus.wr_chnnl = 3'd0;
    bus.wr_data  = 12'h000;
    test_reset();
    test_basic();
    test_write();
    test_abort();
    test_midwrite();
    test_overrun();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
